// File: rtl/mac_learn_ctrl.sv
// rtl/mac_learn_ctrl.sv - MAC table learn/aging controller driving the L2 switch CAM
// Looks up learn requests in the CAM, allocates or refreshes entries and ages out stale ones.
module mac_learn_ctrl #(
  parameter int MAC_WIDTH  = 48,
  parameter int ADDR_WIDTH = 5,
  parameter int PORT_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MAC_WIDTH-1:0]  learn_mac,
  input  logic [PORT_WIDTH-1:0] learn_port,
  input  logic                  learn_valid,
  output logic                  learn_ready,
  output logic                  learn_done,
  output logic                  learn_new,
  output logic [ADDR_WIDTH-1:0] learn_addr,
  input  logic                  age_tick,
  output logic                  age_busy,
  output logic                  table_full,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [PORT_WIDTH-1:0] rd_port,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [MAC_WIDTH-1:0]  cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [MAC_WIDTH-1:0]  cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

  localparam int N = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    INIT, IDLE, LOOKUP, LOOKUP_CHK, WR_REQ, WR_WAIT, AGE_RD
  } state_t;

  state_t                           state_q, state_d;
  logic [N-1:0]                     valid_q, valid_d;
  logic [N-1:0]                     hit_q, hit_d;
  logic [N-1:0][PORT_WIDTH-1:0]     port_table_q, port_table_d;
  logic [ADDR_WIDTH-1:0]            victim_q, victim_d;
  logic [ADDR_WIDTH-1:0]            sweep_q, sweep_d;
  logic                             age_pend_q, age_pend_d;
  logic [MAC_WIDTH-1:0]             mac_q, mac_d;
  logic [PORT_WIDTH-1:0]            port_q, port_d;
  logic [ADDR_WIDTH-1:0]            alloc_q, alloc_d;
  logic                             del_q, del_d;
  logic                             wr_skip_q, wr_skip_d;
  logic                             learn_ready_q, learn_ready_d;
  logic                             learn_done_q, learn_done_d;
  logic                             learn_new_q, learn_new_d;
  logic [ADDR_WIDTH-1:0]            learn_addr_q, learn_addr_d;
  logic                             age_busy_q, age_busy_d;
  logic [ADDR_WIDTH-1:0]            cam_write_addr_q, cam_write_addr_d;
  logic [MAC_WIDTH-1:0]             cam_write_data_q, cam_write_data_d;
  logic                             cam_write_delete_q, cam_write_delete_d;
  logic                             cam_write_enable_q, cam_write_enable_d;
  logic [MAC_WIDTH-1:0]             cam_compare_data_q, cam_compare_data_d;
  logic [ADDR_WIDTH-1:0]            free_addr;
  logic                             advance;

  assign table_full       = &valid_q;
  assign rd_port          = port_table_q[rd_addr];
  assign rd_valid         = valid_q[rd_addr];
  assign learn_ready      = learn_ready_q;
  assign learn_done       = learn_done_q;
  assign learn_new        = learn_new_q;
  assign learn_addr       = learn_addr_q;
  assign age_busy         = age_busy_q;
  assign cam_write_addr   = cam_write_addr_q;
  assign cam_write_data   = cam_write_data_q;
  assign cam_write_delete = cam_write_delete_q;
  assign cam_write_enable = cam_write_enable_q;
  assign cam_compare_data = cam_compare_data_q;

  // Lowest-index free entry; only meaningful when the table is not full.
  always_comb begin
    free_addr = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_addr = ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    state_d            = state_q;
    valid_d            = valid_q;
    hit_d              = hit_q;
    port_table_d       = port_table_q;
    victim_d           = victim_q;
    sweep_d            = sweep_q;
    age_pend_d         = age_pend_q | age_tick;
    mac_d              = mac_q;
    port_d             = port_q;
    alloc_d            = alloc_q;
    del_d              = del_q;
    wr_skip_d          = 1'b0;
    learn_done_d       = 1'b0;
    learn_new_d        = 1'b0;
    learn_addr_d       = learn_addr_q;
    cam_write_addr_d   = cam_write_addr_q;
    cam_write_data_d   = cam_write_data_q;
    cam_write_delete_d = 1'b0;
    cam_write_enable_d = 1'b0;
    cam_compare_data_d = cam_compare_data_q;
    advance            = 1'b0;

    case (state_q)
      INIT: begin
        if (!cam_write_busy) state_d = IDLE;
      end
      IDLE: begin
        if (learn_valid) begin
          mac_d              = learn_mac;
          port_d             = learn_port;
          cam_compare_data_d = learn_mac;
          state_d            = LOOKUP;
        end else if (age_pend_q) begin
          state_d = AGE_RD;
        end
      end
      LOOKUP: begin
        state_d = LOOKUP_CHK;
      end
      LOOKUP_CHK: begin
        if (cam_match && valid_q[cam_match_addr]) begin
          port_table_d[cam_match_addr] = port_q;
          hit_d[cam_match_addr]        = 1'b1;
          learn_done_d                 = 1'b1;
          learn_addr_d                 = cam_match_addr;
          state_d                      = IDLE;
        end else begin
          del_d = 1'b0;
          if (table_full) begin
            alloc_d  = victim_q;
            victim_d = victim_q + 1'b1;
          end else begin
            alloc_d = free_addr;
          end
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!cam_write_busy) begin
          cam_write_enable_d = 1'b1;
          cam_write_delete_d = del_q;
          cam_write_addr_d   = alloc_q;
          cam_write_data_d   = del_q ? '0 : mac_q;
          if (del_q) begin
            valid_d[alloc_q] = 1'b0;
          end else begin
            valid_d[alloc_q]      = 1'b1;
            hit_d[alloc_q]        = 1'b1;
            port_table_d[alloc_q] = port_q;
          end
          wr_skip_d = 1'b1;
          state_d   = WR_WAIT;
        end
      end
      WR_WAIT: begin
        // CAM busy only rises a cycle after it samples the enable.
        if (!wr_skip_q && !cam_write_busy) begin
          if (del_q) begin
            advance = 1'b1;
          end else begin
            learn_done_d = 1'b1;
            learn_new_d  = 1'b1;
            learn_addr_d = alloc_q;
            state_d      = IDLE;
          end
        end
      end
      AGE_RD: begin
        if (valid_q[sweep_q] && !hit_q[sweep_q]) begin
          del_d   = 1'b1;
          alloc_d = sweep_q;
          state_d = WR_REQ;
        end else begin
          if (valid_q[sweep_q]) hit_d[sweep_q] = 1'b0;
          advance = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

    // Step the sweep; a waiting learn request preempts the remaining entries.
    if (advance) begin
      if (&sweep_q) begin
        sweep_d    = '0;
        age_pend_d = 1'b0;
        state_d    = IDLE;
      end else begin
        sweep_d = sweep_q + 1'b1;
        state_d = learn_valid ? IDLE : AGE_RD;
      end
    end

    learn_ready_d = (state_d == IDLE);
    age_busy_d    = age_pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= INIT;
      valid_q            <= '0;
      hit_q              <= '0;
      port_table_q       <= '0;
      victim_q           <= '0;
      sweep_q            <= '0;
      age_pend_q         <= 1'b0;
      mac_q              <= '0;
      port_q             <= '0;
      alloc_q            <= '0;
      del_q              <= 1'b0;
      wr_skip_q          <= 1'b0;
      learn_ready_q      <= 1'b0;
      learn_done_q       <= 1'b0;
      learn_new_q        <= 1'b0;
      learn_addr_q       <= '0;
      age_busy_q         <= 1'b0;
      cam_write_addr_q   <= '0;
      cam_write_data_q   <= '0;
      cam_write_delete_q <= 1'b0;
      cam_write_enable_q <= 1'b0;
      cam_compare_data_q <= '0;
    end else begin
      state_q            <= state_d;
      valid_q            <= valid_d;
      hit_q              <= hit_d;
      port_table_q       <= port_table_d;
      victim_q           <= victim_d;
      sweep_q            <= sweep_d;
      age_pend_q         <= age_pend_d;
      mac_q              <= mac_d;
      port_q             <= port_d;
      alloc_q            <= alloc_d;
      del_q              <= del_d;
      wr_skip_q          <= wr_skip_d;
      learn_ready_q      <= learn_ready_d;
      learn_done_q       <= learn_done_d;
      learn_new_q        <= learn_new_d;
      learn_addr_q       <= learn_addr_d;
      age_busy_q         <= age_busy_d;
      cam_write_addr_q   <= cam_write_addr_d;
      cam_write_data_q   <= cam_write_data_d;
      cam_write_delete_q <= cam_write_delete_d;
      cam_write_enable_q <= cam_write_enable_d;
      cam_compare_data_q <= cam_compare_data_d;
    end
  end

endmodule

// File: tb/tb_mac_learn_ctrl.sv
// tb/tb_mac_learn_ctrl.sv - scoreboard bench for mac_learn_ctrl with a behavioural CAM
module tb_mac_learn_ctrl;

  localparam int N = 32;

  typedef struct {
    logic        del;
    logic [4:0]  addr;
    logic [47:0] data;
  } wr_t;

  typedef struct {
    logic       is_new;
    logic [4:0] addr;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] learn_mac = '0;
  logic [1:0]  learn_port = '0;
  logic        learn_valid = 1'b0;
  logic        learn_ready, learn_done, learn_new;
  logic [4:0]  learn_addr;
  logic        age_tick = 1'b0;
  logic        age_busy, table_full;
  logic [4:0]  rd_addr = '0;
  logic [1:0]  rd_port;
  logic        rd_valid;
  logic [4:0]  cam_write_addr;
  logic [47:0] cam_write_data;
  logic        cam_write_delete, cam_write_enable, cam_write_busy;
  logic [47:0] cam_compare_data;
  logic        cam_match;
  logic [4:0]  cam_match_addr;

  mac_learn_ctrl #(.MAC_WIDTH(48), .ADDR_WIDTH(5), .PORT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .learn_mac(learn_mac), .learn_port(learn_port), .learn_valid(learn_valid),
    .learn_ready(learn_ready), .learn_done(learn_done), .learn_new(learn_new),
    .learn_addr(learn_addr), .age_tick(age_tick), .age_busy(age_busy),
    .table_full(table_full), .rd_addr(rd_addr), .rd_port(rd_port), .rd_valid(rd_valid),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural CAM: zeroing busy after reset, 3-cycle write busy, registered match.
  int          busy_init = 512;
  logic [9:0]  busy_cnt;
  logic [47:0] cam_d [N];
  logic [31:0] cam_v;
  logic        cam_hit_c;
  logic [4:0]  cam_hit_addr_c;

  assign cam_write_busy = (busy_cnt != 0);

  always_comb begin
    cam_hit_c      = 1'b0;
    cam_hit_addr_c = '0;
    for (int i = 0; i < N; i++) begin
      if (cam_v[i] && cam_d[i] == cam_compare_data) begin
        cam_hit_c      = 1'b1;
        cam_hit_addr_c = 5'(i);
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt       <= 10'(busy_init);
      cam_v          <= '0;
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
    end else begin
      if (cam_write_enable) begin
        busy_cnt              <= 10'd3;
        cam_v[cam_write_addr] <= !cam_write_delete;
        cam_d[cam_write_addr] <= cam_write_data;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 10'd1;
      end
      cam_match      <= cam_hit_c;
      cam_match_addr <= cam_hit_addr_c;
    end
  end

  // Scoreboard
  wr_t   exp_wr[$];
  done_t exp_done[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (cam_write_enable) begin
        check_eq("wr_not_busy", cam_write_busy, 1'b0);
        check_eq("wr_expected", exp_wr.size() != 0, 1'b1);
        if (exp_wr.size() != 0) begin
          check_eq("wr_delete", cam_write_delete, exp_wr[0].del);
          check_eq("wr_addr", cam_write_addr, exp_wr[0].addr);
          if (!exp_wr[0].del) check_eq("wr_data", cam_write_data, exp_wr[0].data);
          exp_wr.delete(0);
        end
      end
      if (learn_done) begin
        check_eq("done_expected", exp_done.size() != 0, 1'b1);
        if (exp_done.size() != 0) begin
          check_eq("done_new", learn_new, exp_done[0].is_new);
          check_eq("done_addr", learn_addr, exp_done[0].addr);
          exp_done.delete(0);
        end
      end
    end
  end

  // Reference table
  logic [31:0] ref_valid, ref_hit;
  logic [47:0] ref_mac [N];
  logic [1:0]  ref_port [N];
  int          ref_victim;

  task automatic ref_reset();
    ref_valid  = '0;
    ref_hit    = '0;
    ref_victim = 0;
  endtask

  task automatic do_learn(input logic [47:0] mac, input logic [1:0] port);
    int    a, n, lat;
    bit    found;
    wr_t   w;
    done_t d;
    found = 0;
    a     = -1;
    for (int i = 0; i < N; i++) if (ref_valid[i] && ref_mac[i] == mac) begin found = 1; a = i; end
    if (!found) begin
      for (int i = N - 1; i >= 0; i--) if (!ref_valid[i]) a = i;
      if (a < 0) begin
        a          = ref_victim;
        ref_victim = (ref_victim + 1) % N;
      end
      w.del = 1'b0; w.addr = a[4:0]; w.data = mac;
      exp_wr.push_back(w);
      ref_valid[a] = 1'b1;
      ref_mac[a]   = mac;
    end
    ref_hit[a]  = 1'b1;
    ref_port[a] = port;
    d.is_new = !found; d.addr = a[4:0];
    exp_done.push_back(d);

    learn_mac = mac; learn_port = port; learn_valid = 1'b1;
    n = 0;
    while (!learn_ready && n < 2000) begin @(posedge clk); #1; n++; end
    check_eq("learn_accept_timeout", n < 2000, 1'b1);
    @(posedge clk); #1;
    learn_valid = 1'b0;
    lat = 1;
    while (!learn_done && lat < 200) begin @(posedge clk); #1; lat++; end
    check_eq("learn_done_timeout", lat < 200, 1'b1);
    if (found) check_eq("hit_latency", lat, 3);
    @(posedge clk); #1;
  endtask

  task automatic check_rd(input int a);
    rd_addr = a[4:0];
    #1;
    check_eq("rd_valid", rd_valid, ref_valid[a]);
    if (ref_valid[a]) check_eq("rd_port", rd_port, ref_port[a]);
  endtask

  task automatic age_expect();
    wr_t w;
    for (int i = 0; i < N; i++) begin
      if (ref_valid[i]) begin
        if (ref_hit[i]) begin
          ref_hit[i] = 1'b0;
        end else begin
          w.del = 1'b1; w.addr = 5'(i); w.data = '0;
          exp_wr.push_back(w);
          ref_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse_age_tick();
    age_tick = 1'b1;
    @(posedge clk); #1;
    age_tick = 1'b0;
    check_eq("age_busy_set", age_busy, 1'b1);
  endtask

  task automatic wait_age_done();
    int n;
    n = 0;
    while (age_busy && n < 5000) begin @(posedge clk); #1; n++; end
    check_eq("age_done_timeout", n < 5000, 1'b1);
    check_eq("age_busy_clear", age_busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_learn_ready", learn_ready, 1'b0);
    check_eq("rst_learn_done", learn_done, 1'b0);
    check_eq("rst_learn_new", learn_new, 1'b0);
    check_eq("rst_learn_addr", learn_addr, 5'd0);
    check_eq("rst_age_busy", age_busy, 1'b0);
    check_eq("rst_table_full", table_full, 1'b0);
    check_eq("rst_wr_enable", cam_write_enable, 1'b0);
    check_eq("rst_wr_delete", cam_write_delete, 1'b0);
    check_eq("rst_wr_addr", cam_write_addr, 5'd0);
    check_eq("rst_wr_data", cam_write_data, 48'd0);
    check_eq("rst_cmp_data", cam_compare_data, 48'd0);
  endtask

  task automatic wait_init_done(input string tag);
    int n, ready_bad;
    n = 0; ready_bad = 0;
    while (cam_write_busy && n < 2000) begin
      if (learn_ready) ready_bad++;
      @(posedge clk); #1; n++;
    end
    check_eq(tag, n < 2000, 1'b1);
    check_eq("init_ready_low", ready_bad, 0);
    check_eq("init_ready_at_fall", learn_ready, 1'b0);
    @(posedge clk); #1;
    check_eq("init_ready_after_fall", learn_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [47:0] m;
    int          n;
    wr_t         w;

    ref_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    wait_init_done("init_timeout");

    // First learn into an empty table, then a refresh hit on another port.
    do_learn(48'h001122334455, 2'd2);
    check_rd(0);
    do_learn(48'h001122334455, 2'd1);
    check_rd(0);

    // Fill the table, then overwrite via the victim pointer.
    for (int i = 1; i < N; i++) do_learn(48'h020000000000 + 48'(i), 2'(i % 4));
    check_eq("table_full", table_full, 1'b1);
    do_learn(48'h0300000000AA, 2'd3);
    do_learn(48'h0300000000BB, 2'd0);
    check_rd(0);
    check_rd(1);

    // Reset while the CAM write is in flight; the learn never completes.
    busy_init = 40;
    m = 48'h0A0B0C0D0E0F;
    w.del = 1'b0; w.addr = 5'(ref_victim); w.data = m;
    exp_wr.push_back(w);
    learn_mac = m; learn_port = 2'd2; learn_valid = 1'b1;
    n = 0;
    while (!learn_ready && n < 2000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    learn_valid = 1'b0;
    n = 0;
    while (!cam_write_enable && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("rst_wr_seen", cam_write_enable, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ref_reset();
    wait_init_done("reinit_timeout");

    // Aging: a refreshed entry survives, an untouched one is deleted.
    do_learn(48'h0400000000A0, 2'd1);
    do_learn(48'h0400000000A1, 2'd2);
    age_expect();
    pulse_age_tick();
    wait_age_done();
    do_learn(48'h0400000000A1, 2'd3);
    age_expect();
    pulse_age_tick();
    wait_age_done();
    check_rd(0);
    check_rd(1);

    // Sweep yields to a learn arriving mid-sweep and then resumes.
    for (int i = 0; i < 9; i++) do_learn(48'h050000000000 + 48'(i), 2'(i % 4));
    age_expect();
    pulse_age_tick();
    wait_age_done();
    for (int i = 0; i < 6; i++) begin
      if (ref_valid[i]) do_learn(ref_mac[i], 2'd1);
      else do_learn(48'h0600000000C0, 2'd1);
    end
    age_expect();
    pulse_age_tick();
    repeat (6) @(posedge clk);
    #1;
    check_eq("yield_age_busy", age_busy, 1'b1);
    do_learn(ref_mac[3], 2'd2);
    wait_age_done();
    for (int i = 0; i < 10; i++) check_rd(i);

    repeat (5) @(posedge clk);
    #1;
    check_eq("wr_q_drained", exp_wr.size(), 0);
    check_eq("done_q_drained", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_learn_ctrl.md
Name: mac_learn_ctrl

Overview:
- Initiator for the L2 switch MAC table CAM: drives the CAM write port (addr/data/delete/enable, paced by busy) and owns its compare port.
- Accepts source-MAC learn requests from the ingress parser and looks each one up. On a hit it refreshes the entry; on a miss it allocates an entry and writes it into the CAM.
- Keeps a per-entry egress-port table and valid/hit bits, and runs periodic aging sweeps that delete stale entries through the CAM delete path.

Parameters:
- MAC_WIDTH, 48, CAM data width (MAC address).
- ADDR_WIDTH, 5, log2 of CAM entries; N = 2**ADDR_WIDTH.
- PORT_WIDTH, 2, egress port number width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- learn_mac  in  MAC_WIDTH  source MAC to learn
- learn_port  in  PORT_WIDTH  ingress port of learn_mac
- learn_valid  in  1  request valid
- learn_ready  out  1  request accepted when valid&ready
- learn_done  out  1  one-cycle pulse at end of each learn
- learn_new  out  1  qualifies learn_done: 1 = miss/allocated, 0 = hit
- learn_addr  out  ADDR_WIDTH  entry used; valid with learn_done
- age_tick  in  1  pulse requesting an aging sweep
- age_busy  out  1  sweep pending or in progress
- table_full  out  1  all N entries valid
- rd_addr  in  ADDR_WIDTH  forwarding read address (CAM match_addr)
- rd_port  out  PORT_WIDTH  port_table[rd_addr], combinational
- rd_valid  out  1  valid[rd_addr], combinational
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr
- cam_write_data  out  MAC_WIDTH  to CAM write_data
- cam_write_delete  out  1  to CAM write_delete
- cam_write_enable  out  1  to CAM write_enable
- cam_write_busy  in  1  from CAM write_busy
- cam_compare_data  out  MAC_WIDTH  to CAM compare_data
- cam_match  in  1  from CAM match
- cam_match_addr  in  ADDR_WIDTH  from CAM match_addr

Behaviour:
- Reset (async):
  - state=INIT; valid, hit bits, port table, victim pointer and sweep counter all 0.
  - Outputs: learn_ready=0, learn_done=0, learn_new=0, learn_addr=0, age_busy=0, cam_write_enable=0, cam_write_delete=0, cam_write_addr=0, cam_write_data=0, cam_compare_data=0.
- Output qualification: all outputs are registered except rd_port/rd_valid. table_full = &valid.
- INIT: wait while cam_write_busy=1 (CAM zeroing RAMs) -> IDLE.
- IDLE: learn_ready=1. Priority order:
  1. learn_valid: capture mac/port, drive cam_compare_data=mac -> LOOKUP.
  2. else age pending: age_busy stays 1 -> AGE_RD.
  3. else stay.
- Aging request: age_tick sets the age-pending flag in any state; ticks while pending/sweeping are absorbed.
- LOOKUP: one wait cycle (CAM BRAM read latency) -> LOOKUP_CHK. cam_compare_data stays held until the next request.
- LOOKUP_CHK: sample cam_match/cam_match_addr.
  - Hit (match and valid[match_addr]): port_table[a]<=port, hit[a]<=1, learn_done=1, learn_new=0, learn_addr=a -> IDLE. Total 3 cycles from acceptance to done, no CAM write.
  - Miss: alloc = lowest-index entry with valid=0. If table_full, alloc = victim pointer, and the pointer increments mod N. -> WR_REQ.
- WR_REQ: wait for cam_write_busy=0, then:
  - drive cam_write_enable=1 for exactly one cycle, cam_write_delete=0, cam_write_addr=alloc, cam_write_data=mac;
  - update valid[alloc]<=1, hit[alloc]<=1, port_table[alloc]<=port;
  - -> WR_WAIT.
- WR_WAIT: skip the first cycle (CAM busy is registered), then wait for cam_write_busy=0.
  - Then: learn_done=1, learn_new=1, learn_addr=alloc -> IDLE.
  - A victim overwrite needs no separate delete: the CAM clears the old data at that address itself.
- Aging sweep: sweep counter s runs 0..N-1, one entry per visit.
  - AGE_RD, entry valid and hit=1: clear hit; go to the next entry.
  - AGE_RD, entry valid and hit=0 (stale): issue a CAM delete via the WR_REQ/WR_WAIT handshake with cam_write_delete=1 and cam_write_addr=s, clear valid[s], then continue.
  - AGE_RD, entry invalid: skip it.
  - Yield point: after each entry, if learn_valid=1, return to IDLE and service the learn first. s is retained; the sweep resumes afterwards.
  - Completion: after entry N-1, s wraps to 0, the pending flag clears and age_busy deasserts.
- Write enable discipline: cam_write_enable is never asserted while cam_write_busy=1 or in INIT.
- Reset mid-operation: returns to INIT immediately. Any in-flight learn is dropped with no learn_done. The CAM is reset by the same rst and re-zeroes itself.

Test Plan:
- Reset, CAM busy for 512 cycles -> learn_ready=0 throughout; learn_ready=1 the cycle after cam_write_busy falls.
- Learn MAC 0x001122334455 on port 2, empty table -> one write with addr=0, delete=0, data=0x001122334455; learn_done with learn_new=1, learn_addr=0; rd_addr=0 gives rd_valid=1, rd_port=2.
- Same MAC again on port 1 (model CAM returns match, addr 0) -> no cam_write_enable; learn_done with learn_new=0 exactly 3 cycles after acceptance; rd_port=1.
- Fill all 32 entries (table_full=1), then learn a 33rd MAC -> overwrite at addr 0 (victim pointer), pointer becomes 1; a 34th MAC -> addr 1.
- Learn entries 0 and 1, age_tick, re-learn entry 1 (hit), age_tick -> second sweep issues exactly one delete, at addr 0 (delete=1); valid[0]=0, valid[1]=1; age_busy falls after the sweep.
- learn_valid asserted mid-sweep at s=5 -> learn serviced first; sweep resumes at the next entry and completes; rst pulsed during WR_WAIT -> all outputs at reset values asynchronously, no learn_done.
